// File: rtl/mult_fu_pipe_pkg.sv
// mult_fu_pipe_pkg: shared execute types, multiply op encoding and pipeline stage record
package mult_fu_pipe_pkg;
    localparam int XLEN            = 32;
    localparam int MULT_MAX_STAGES = 8;
    localparam int PREG_W          = 6;
    localparam int ROB_W           = 5;

    typedef enum logic [1:0] {MUL, MULH, MULHSU, MULHU} fu_mult_op_e;

    typedef union packed {
        fu_mult_op_e mult;
        logic [1:0]  raw;
    } fu_func_t;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   opa;
        logic [XLEN-1:0]   opb;
        fu_func_t          fu_func;
        logic [PREG_W-1:0] phy_dest_reg;
        logic [ROB_W-1:0]  rob_index;
    } execute_packet_t;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   value;
        logic [PREG_W-1:0] phy_dest_reg;
        logic [ROB_W-1:0]  rob_index;
    } fu_result_t;

    typedef struct packed {
        logic              valid;
        fu_mult_op_e       op;
        logic [2*XLEN-1:0] psum;
        logic [2*XLEN-1:0] opa_ext;
        logic [2*XLEN-1:0] opb_ext;
        logic [PREG_W-1:0] phy_dest_reg;
        logic [ROB_W-1:0]  rob_index;
    } mult_stage_t;

    function automatic logic [2*XLEN-1:0] ext(input logic [XLEN-1:0] v, input logic s);
        return {{XLEN{s & v[XLEN-1]}}, v};
    endfunction
endpackage

// File: rtl/mult_stage.sv
// mult_stage: one pipeline register; adds its multiplier-slice partial product on load
module mult_stage
    import mult_fu_pipe_pkg::*;
#(
    parameter int K = 0,
    parameter int W = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        en,
    input  mult_stage_t d,
    output mult_stage_t q
);
    logic [2*XLEN-1:0] chunk;

    // Zero-extend this stage's multiplier slice so the partial product stays unsigned
    always_comb begin
        chunk = '0;
        chunk[W-1:0] = d.opb_ext[K*W +: W];
    end

    // Load the incoming op with its partial product accumulated; flush only kills validity
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (flush) begin
            q.valid <= 1'b0;
        end else if (en) begin
            q      <= d;
            q.psum <= d.psum + ((d.opa_ext * chunk) << (K*W));
        end
    end
endmodule

// File: rtl/mult_fu_pipe.sv
// mult_fu_pipe: pipelined RV32M multiply unit with bubble-collapsing backpressure (optional MULT_STALL_CNT_EN stall counter)
module mult_fu_pipe
    import mult_fu_pipe_pkg::*;
#(
    parameter int STAGES = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  execute_packet_t in_packet,
    output logic            in_ready,
    output fu_result_t      out_packet,
    input  logic            out_grant
`ifdef MULT_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cycles
`endif
);
    localparam int W = 2*XLEN/STAGES;
    localparam int L = STAGES-1;

    mult_stage_t       d [STAGES];
    mult_stage_t       q [STAGES];
    logic [STAGES-1:0] vld, adv, take;

    // Advance chain runs from the output back so a retiring last stage frees every stage behind it
    always_comb begin
        for (int k = 0; k < STAGES; k++) vld[k] = q[k].valid;
        adv[L] = vld[L] && out_grant;
        for (int k = L-1; k >= 0; k--) adv[k] = vld[k] && (!vld[k+1] || adv[k+1]);
        in_ready = ~&vld;
        take[0] = in_packet.valid && in_ready;
        for (int k = 1; k < STAGES; k++) take[k] = adv[k-1];
    end

    // Stage inputs: stage 0 extends operands per op, later stages take their predecessor
    always_comb begin
        d[0].valid        = take[0];
        d[0].op           = in_packet.fu_func.mult;
        d[0].psum         = '0;
        d[0].opa_ext      = ext(in_packet.opa, in_packet.fu_func.mult != MULHU);
        d[0].opb_ext      = ext(in_packet.opb, in_packet.fu_func.mult inside {MUL, MULH});
        d[0].phy_dest_reg = in_packet.phy_dest_reg;
        d[0].rob_index    = in_packet.rob_index;
        for (int k = 1; k < STAGES; k++) begin
            d[k]       = q[k-1];
            d[k].valid = take[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        mult_stage #(.K(k), .W(W)) u_stage (
            .clock (clock),
            .reset (reset),
            .flush (flush),
            .en    (take[k] | adv[k]),
            .d     (d[k]),
            .q     (q[k])
        );
    end

    // Result comes straight off the last stage: low half for MUL, high half otherwise
    always_comb begin
        out_packet.valid        = q[L].valid;
        out_packet.value        = q[L].op == MUL ? q[L].psum[XLEN-1:0] : q[L].psum[2*XLEN-1:XLEN];
        out_packet.phy_dest_reg = q[L].phy_dest_reg;
        out_packet.rob_index    = q[L].rob_index;
    end

`ifdef MULT_STALL_CNT_EN
    // Count cycles a finished result waits on the CDB; saturates and survives flush
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) stall_cycles <= '0;
        else if (out_packet.valid && !out_grant && !flush && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_mult_fu_pipe.sv
// tb_mult_fu_pipe: scoreboard bench for mult_fu_pipe (covers MULT_STALL_CNT_EN when defined)
module tb_mult_fu_pipe;
    import mult_fu_pipe_pkg::*;

    localparam int STAGES = 4;
    typedef logic [XLEN+PREG_W+ROB_W-1:0] sb_t;

    logic            clock = 1'b0;
    logic            reset, flush, out_grant, in_ready;
    execute_packet_t in_packet;
    fu_result_t      out_packet;
`ifdef MULT_STALL_CNT_EN
    logic [31:0]     stall_cycles;
`endif
    int              checks, fails;
    logic [4:0]      tag;
    sb_t             sb [$];
    sb_t             exp_e, got_e;

    mult_fu_pipe #(.STAGES(STAGES)) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .in_packet    (in_packet),
        .in_ready     (in_ready),
        .out_packet   (out_packet),
        .out_grant    (out_grant)
`ifdef MULT_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input fu_mult_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ae, be, p;
        ae = (op == MULHU) ? {32'h0, a} : {{32{a[31]}}, a};
        be = (op == MUL || op == MULH) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ae * be;
        return (op == MUL) ? p[31:0] : p[63:32];
    endfunction

    // Scoreboard: push on accept, pop and compare on retire; squash on flush/reset
    always @(negedge clock) begin
        if (!reset || flush) begin
            sb.delete();
        end else begin
            if (out_packet.valid) begin
                got_e = {out_packet.value, out_packet.phy_dest_reg, out_packet.rob_index};
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL sb_stale: out valid value=%h rob=%0d, expected no valid output", out_packet.value, out_packet.rob_index);
                end else if (out_grant) begin
                    checks++;
                    exp_e = sb.pop_front();
                    if (got_e !== exp_e) begin
                        fails++;
                        $display("FAIL sb_result: got %h expected %h (value,pdr,rob)", got_e, exp_e);
                    end
                end
            end
            if (in_packet.valid && in_ready)
                sb.push_back({model(in_packet.fu_func.mult, in_packet.opa, in_packet.opb),
                              in_packet.phy_dest_reg, in_packet.rob_index});
        end
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input fu_mult_op_e op, input logic [31:0] a, input logic [31:0] b);
        in_packet.valid        = 1'b1;
        in_packet.opa          = a;
        in_packet.opb          = b;
        in_packet.fu_func.mult = op;
        in_packet.rob_index    = tag;
        in_packet.phy_dest_reg = {1'b0, tag} + 6'd7;
        tag++;
    endtask

    task automatic idle;
        in_packet.valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) step;
        checks++; if (out_packet !== '0) begin fails++; $display("FAIL reset_out: got %h expected 0", out_packet); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
`ifdef MULT_STALL_CNT_EN
        checks++; if (stall_cycles !== 32'd0) begin fails++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles); end
`endif
        reset = 1'b1;
        out_grant = 1'b1;
        drive(MUL, 32'd2, 32'd3);
        step;
        idle;
        repeat (3) step;
        checks++;
        if (out_packet.valid !== 1'b1 || out_packet.value !== 32'd6) begin
            fails++; $display("FAIL reset_first_op: got valid=%b value=%h expected valid=1 value=6", out_packet.valid, out_packet.value);
        end
        step;
    endtask

    task automatic test_ops;
        fu_mult_op_e ops [5] = '{MUL, MULH, MULHSU, MULHU, MULH};
        logic [31:0] av  [5] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] bv  [5] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ev  [5] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0000};
        int n;
        out_grant = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], av[i], bv[i]);
            n = 0;
            do begin
                step;
                if (n == 0) idle;
                n++;
            end while (!out_packet.valid && n < 12);
            checks++; if (n !== STAGES) begin fails++; $display("FAIL ops_latency[%0d]: got %0d cycles expected %0d", i, n, STAGES); end
            checks++; if (out_packet.value !== ev[i]) begin fails++; $display("FAIL ops_value[%0d]: got %h expected %h", i, out_packet.value, ev[i]); end
            step;
        end
    endtask

    task automatic test_backpressure;
        int acc;
        int n;
        fu_result_t snap;
        out_grant = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(fu_mult_op_e'($urandom_range(0, 3)), $urandom, $urandom);
            if (in_ready) acc++;
            step;
        end
        idle;
        checks++; if (acc !== 4) begin fails++; $display("FAIL bp_accepts: got %0d expected 4", acc); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready: got %b expected 0", in_ready); end
        snap = out_packet;
        checks++; if (snap.valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid: got %b expected 1", snap.valid); end
        for (int i = 0; i < 4; i++) begin
            step;
            checks++; if (out_packet !== snap) begin fails++; $display("FAIL bp_stable[%0d]: got %h expected %h", i, out_packet, snap); end
        end
        out_grant = 1'b1;
        n = 0;
        while ((sb.size() != 0 || out_packet.valid) && n < 20) begin step; n++; end
        checks++; if (sb.size() !== 0) begin fails++; $display("FAIL bp_drain: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_bubble;
        int acc;
        int n;
        out_grant = 1'b0;
        drive(MULHU, $urandom, $urandom);
        step; idle; step; step;
        drive(MULHSU, $urandom, $urandom);
        step; idle;
        repeat (3) step;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bubble_ready_two_held: got %b expected 1", in_ready); end
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            drive(MUL, $urandom, $urandom);
            if (in_ready) acc++;
            step;
        end
        idle;
        checks++; if (acc !== 2) begin fails++; $display("FAIL bubble_accepts: got %0d expected 2", acc); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bubble_full: got %b expected 0", in_ready); end
        out_grant = 1'b1;
        n = 0;
        while ((sb.size() != 0 || out_packet.valid) && n < 20) begin step; n++; end
        checks++; if (sb.size() !== 0) begin fails++; $display("FAIL bubble_drain: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_flush;
        int stale;
        int n;
        out_grant = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(MULH, $urandom, $urandom);
            step;
        end
        drive(MUL, 32'd5, 32'd5);
        flush = 1'b1;
        step;
        flush = 1'b0;
        idle;
        checks++; if (out_packet.valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b expected 0", out_packet.valid); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_ready: got %b expected 1", in_ready); end
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            step;
            if (out_packet.valid) stale++;
        end
        checks++; if (stale !== 0) begin fails++; $display("FAIL flush_stale: got %0d valid cycles expected 0", stale); end
        drive(MULHSU, 32'h1234_5678, 32'h9ABC_DEF0);
        step; idle;
        n = 0;
        while ((sb.size() != 0 || out_packet.valid) && n < 20) begin step; n++; end
        checks++; if (sb.size() !== 0) begin fails++; $display("FAIL flush_after_drain: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_random;
        int n;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) != 0) drive(fu_mult_op_e'($urandom_range(0, 3)), $urandom, $urandom);
            else idle;
            out_grant = $urandom_range(0, 9) < 7;
            step;
        end
        idle;
        out_grant = 1'b1;
        n = 0;
        while ((sb.size() != 0 || out_packet.valid) && n < 20) begin step; n++; end
        checks++; if (sb.size() !== 0) begin fails++; $display("FAIL random_drain: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_async_reset;
        out_grant = 1'b0;
        drive(MULHU, 32'hFFFF_FFFF, 32'h2);
        step; idle;
        repeat (3) step;
        checks++; if (out_packet.valid !== 1'b1) begin fails++; $display("FAIL areset_pre_valid: got %b expected 1", out_packet.valid); end
        #2 reset = 1'b0;
        #1;
        checks++; if (out_packet.valid !== 1'b0) begin fails++; $display("FAIL areset_valid: got %b expected 0", out_packet.valid); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL areset_ready: got %b expected 1", in_ready); end
        step;
        reset = 1'b1;
        step;
    endtask

`ifdef MULT_STALL_CNT_EN
    task automatic test_stall_cnt;
        out_grant = 1'b0;
        drive(MUL, 32'd9, 32'd9);
        step; idle;
        repeat (3) step;
        repeat (5) step;
        out_grant = 1'b1;
        step;
        checks++; if (stall_cycles !== 32'd5) begin fails++; $display("FAIL stall_count: got %0d expected 5", stall_cycles); end
        flush = 1'b1;
        step;
        flush = 1'b0;
        checks++; if (stall_cycles !== 32'd5) begin fails++; $display("FAIL stall_flush: got %0d expected 5", stall_cycles); end
        #2 reset = 1'b0;
        #1;
        checks++; if (stall_cycles !== 32'd0) begin fails++; $display("FAIL stall_reset: got %0d expected 0", stall_cycles); end
        step;
        reset = 1'b1;
        step;
    endtask
`endif

    initial begin
        checks = 0;
        fails = 0;
        tag = '0;
        reset = 1'b0;
        flush = 1'b0;
        out_grant = 1'b0;
        in_packet = '0;
        in_packet.valid = 1'b1;
        test_reset;
        test_ops;
        test_backpressure;
        test_bubble;
        test_flush;
        test_random;
        test_async_reset;
`ifdef MULT_STALL_CNT_EN
        test_stall_cnt;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
